credit_return_unit: RTL

Receiver-side credit generator for a simulated network link. Each freed input-buffer slot becomes one pending credit, and the unit returns those credits upstream one at a time over a valid/ack handshake. The upstream end of the handshake is the sender-side credit counter. Each credit return is delayed by a configurable number of simulation time ticks to model link latency. The unit sits at every router input port, beside the input buffer, and occupies one slot in the configuration chain.

---
 rtl/credit_return_unit_pkg.sv | 12 +
 rtl/credit_return_unit_sat_counter.sv | 30 +++
 rtl/credit_return_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/credit_return_unit_pkg.sv
// Shared definitions for the receiver-side credit return unit and the
// sender-side counter: FSM encodings and default widths.
package credit_return_unit_pkg;
  localparam int CRU_WIDTH  = 4;
  localparam int CRU_DWIDTH = 3;

  typedef enum logic [1:0] {
    CRU_IDLE = 2'd0,
    CRU_WAIT = 2'd1,
    CRU_SEND = 2'd2
  } cru_state_e;
endpackage

// File: rtl/credit_return_unit_sat_counter.sv
// Saturating up/down counter with synchronous clear and a sticky flag
// raised when an increment is dropped at full scale.
module sat_updown_counter
  import credit_return_unit_pkg::*;
#(
  parameter int WIDTH = CRU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             saturated,
  output logic             overflow
);
  assign saturated = &count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (saturated) overflow <= 1'b1;
      else           count    <= count + WIDTH'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end
endmodule

// File: rtl/credit_return_unit.sv
// Receiver-side credit generator: counts freed buffer slots and returns them
// upstream one at a time, each delayed by r_delay simulation ticks.
module credit_return_unit
  import credit_return_unit_pkg::*;
#(
  parameter int WIDTH  = CRU_WIDTH,
  parameter int DWIDTH = CRU_DWIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sim_time_tick,
  input  logic [DWIDTH-1:0] config_in,
  input  logic              config_in_valid,
  output logic [DWIDTH-1:0] config_out,
  output logic              config_out_valid,
  input  logic              free_in,
  output logic              credit_out_valid,
  input  logic              credit_out_ack,
  output logic [WIDTH-1:0]  pending_out,
  output logic              overflow
);
  cru_state_e        state, state_nxt;
  logic [DWIDTH-1:0] r_delay;
  logic [DWIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0]  r_pending;
  logic [WIDTH-1:0]  pend_after_ack;
  logic              accept;
  logic              saturated;

  assign config_out       = r_delay;
  assign config_out_valid = config_in_valid;
  assign credit_out_valid = (state == CRU_SEND) && enable;
  assign accept           = credit_out_valid && credit_out_ack;
  assign pending_out      = r_pending;

  sat_updown_counter #(.WIDTH(WIDTH)) u_pending (
    .clock     (clock),
    .reset     (reset),
    .clear     (config_in_valid),
    .inc       (free_in),
    .dec       (accept),
    .count     (r_pending),
    .saturated (saturated),
    .overflow  (overflow)
  );

  // A free arriving alongside the ack replaces the credit being returned.
  assign pend_after_ack = free_in ? r_pending : r_pending - WIDTH'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (enable) begin
      case (state)
        CRU_IDLE: begin
          if (r_pending != '0) begin
            if (r_delay == '0) begin
              state_nxt = CRU_SEND;
            end else begin
              state_nxt = CRU_WAIT;
              cnt_nxt   = r_delay;
            end
          end
        end
        CRU_WAIT: begin
          if (sim_time_tick) begin
            cnt_nxt = cnt - DWIDTH'(1);
            if (cnt <= DWIDTH'(1)) state_nxt = CRU_SEND;
          end
        end
        CRU_SEND: begin
          if (credit_out_ack) begin
            if (pend_after_ack == '0) begin
              state_nxt = CRU_IDLE;
            end else if (r_delay != '0) begin
              state_nxt = CRU_WAIT;
              cnt_nxt   = r_delay;
            end
          end
        end
        default: state_nxt = CRU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CRU_IDLE;
      cnt     <= '0;
      r_delay <= '0;
    end else if (config_in_valid) begin
      state   <= CRU_IDLE;
      cnt     <= '0;
      r_delay <= config_in;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
    end
  end
endmodule
